// File: rtl/axi_size_pkg.sv
// axi_size_pkg: shared types and lane constants for the 32->64 W packing path
package axi_size_pkg;
  typedef struct packed {
    logic       offset;
    logic [7:0] len;
  } w_pack_cmd_t;
  typedef enum logic {IDLE, PACK} w_pack_state_e;
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;
endpackage

// File: rtl/axi_size_cmd_fifo.sv
// axi_size_cmd_fifo: generic synchronous FIFO with asynchronous active-high reset
module axi_size_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full_o  = count == (AW+1)'(DEPTH);
  assign empty_o = count == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/axi_w_pack_32_64.sv
// axi_w_pack_32_64: packs 32-bit W beats into 64-bit W beats per AW command.
// AXI_W_PACK_LAST_CHECK_EN enables the sticky s_w_last_i mismatch flag on err_o.
module axi_w_pack_32_64
  import axi_size_pkg::*;
#(
  parameter int AXI_USER_WIDTH = 6,
  parameter int CMD_DEPTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_offset_i,
  input  logic [7:0]                cmd_len_i,
  input  logic                      s_w_valid_i,
  input  logic [31:0]               s_w_data_i,
  input  logic [3:0]                s_w_strb_i,
  input  logic [AXI_USER_WIDTH-1:0] s_w_user_i,
  input  logic                      s_w_last_i,
  output logic                      s_w_ready_o,
  output logic                      m_w_valid_o,
  output logic [63:0]               m_w_data_o,
  output logic [7:0]                m_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0] m_w_user_o,
  output logic                      m_w_last_o,
  input  logic                      m_w_ready_i,
  output logic                      err_o
);
  w_pack_cmd_t cmd_in, cmd_out;
  w_pack_state_e state_q, state_d;
  logic fifo_full, fifo_empty, pop, accept, complete, cnt_zero;
  logic lane_q;
  logic [7:0] cnt_q;
  logic [63:0] stage_data, word_data;
  logic [7:0] stage_strb, word_strb;
  assign cmd_in = {cmd_offset_i, cmd_len_i};
  axi_size_cmd_fifo #(.WIDTH($bits(w_pack_cmd_t)), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .data_o  (cmd_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign cmd_ready_o = !fifo_full;
  assign cnt_zero = cnt_q == 8'd0;
  assign complete = lane_q == LANE_HI || cnt_zero;
  // Only a word-completing beat needs room in the output register
  assign s_w_ready_o = state_q == PACK && (!complete || !m_w_valid_o || m_w_ready_i);
  assign accept = s_w_valid_i && s_w_ready_o;
  assign word_data = lane_q == LANE_HI ? {s_w_data_i, stage_data[31:0]} : {stage_data[63:32], s_w_data_i};
  assign word_strb = lane_q == LANE_HI ? {s_w_strb_i, stage_strb[3:0]} : {stage_strb[7:4], s_w_strb_i};
  always_comb begin
    pop = !fifo_empty && (state_q == IDLE || (accept && cnt_zero));
    state_d = pop ? PACK : (accept && cnt_zero) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q      <= LANE_LO;
      cnt_q       <= '0;
      stage_data  <= '0;
      stage_strb  <= '0;
      m_w_valid_o <= 1'b0;
      m_w_data_o  <= '0;
      m_w_strb_o  <= '0;
      m_w_user_o  <= '0;
      m_w_last_o  <= 1'b0;
    end else begin
      if (pop) begin
        lane_q <= cmd_out.offset;
        cnt_q  <= cmd_out.len;
      end else if (accept) begin
        lane_q <= ~lane_q;
        cnt_q  <= cnt_q - 8'd1;
      end
      if (accept && complete) begin
        stage_data <= '0;
        stage_strb <= '0;
        m_w_data_o <= word_data;
        m_w_strb_o <= word_strb;
        m_w_user_o <= s_w_user_i;
        m_w_last_o <= cnt_zero;
      end else if (accept) begin
        stage_data <= word_data;
        stage_strb <= word_strb;
      end
      m_w_valid_o <= (accept && complete) || (m_w_valid_o && !m_w_ready_i);
    end
  end
`ifdef AXI_W_PACK_LAST_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else if (accept && (s_w_last_i != cnt_zero)) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_w_pack_32_64.sv
// tb_axi_w_pack_32_64: randomized scoreboard bench for the 32->64 W packer
module tb_axi_w_pack_32_64;
  localparam int UW = 6;
  typedef struct {
    logic [63:0]   data;
    logic [63:0]   mask;
    logic [7:0]    strb;
    logic [UW-1:0] user;
    logic          last;
  } exp_t;
  typedef struct {
    logic [31:0]   data;
    logic [3:0]    strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;
  typedef struct {
    logic       offset;
    logic [7:0] len;
  } cmd_t;

  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_offset = 0;
  logic [7:0] cmd_len = 0;
  logic s_valid = 0, s_ready, s_last = 0;
  logic [31:0] s_data = 0;
  logic [3:0] s_strb = 0;
  logic [UW-1:0] s_user = 0;
  logic m_valid, m_last, m_ready = 0, err;
  logic [63:0] m_data;
  logic [7:0] m_strb;
  logic [UW-1:0] m_user;

  int tests = 0, fails = 0;
  exp_t exp_q[$];
  beat_t beat_q[$];
  cmd_t cmd_q[$];
  bit rand_valid = 0, rand_ready = 0, hold_off = 0;

  always #5 clk = ~clk;

  axi_w_pack_32_64 #(.AXI_USER_WIDTH(UW), .CMD_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_offset_i(cmd_offset), .cmd_len_i(cmd_len),
    .s_w_valid_i(s_valid), .s_w_data_i(s_data), .s_w_strb_i(s_strb), .s_w_user_i(s_user),
    .s_w_last_i(s_last), .s_w_ready_o(s_ready),
    .m_w_valid_o(m_valid), .m_w_data_o(m_data), .m_w_strb_o(m_strb), .m_w_user_o(m_user),
    .m_w_last_o(m_last), .m_w_ready_i(m_ready), .err_o(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: beat i of a burst lands at 32-bit position offset+i; word = pos/2, lane = pos%2
  task automatic gen_burst(input logic off, input int len, input int mode, input int bad);
    exp_t w[$];
    exp_t e;
    beat_t b;
    cmd_t c;
    for (int i = 0; i <= len; i++) begin
      int p, wi, ln;
      p = int'(off) + i;
      wi = p / 2;
      ln = p % 2;
      b.data = mode == 1 ? 32'(i + 1) : mode == 2 ? 32'hA5A5_A5A5 : $urandom;
      b.strb = mode != 0 ? 4'hF : 4'($urandom);
      b.user = UW'($urandom);
      b.last = (i == len) ^ (i == bad);
      beat_q.push_back(b);
      while (w.size() <= wi) begin
        e.data = '0; e.mask = '0; e.strb = '0; e.user = '0; e.last = 0;
        w.push_back(e);
      end
      e = w[wi];
      e.data[ln*32 +: 32] = b.data;
      e.mask[ln*32 +: 32] = '1;
      e.strb[ln*4 +: 4] = b.strb;
      e.user = b.user;
      w[wi] = e;
    end
    e = w[w.size()-1];
    e.last = 1;
    w[w.size()-1] = e;
    if (w.size() != (int'(off) + len + 2) / 2) begin
      fails++;
      $display("FAIL model_beats: got %0d, expected %0d", w.size(), (int'(off) + len + 2) / 2);
    end
    foreach (w[k]) exp_q.push_back(w[k]);
    c.offset = off;
    c.len = 8'(len);
    cmd_q.push_back(c);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0 || cmd_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL %s_timeout: %0d beats still expected, required 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : cmd_drv
    bit fire;
    forever begin
      @(negedge clk);
      fire = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (fire) void'(cmd_q.pop_front());
      if (cmd_q.size() > 0 && ((cmd_valid && !fire) || !rand_valid || $urandom_range(3) != 0)) begin
        cmd_valid = 1;
        cmd_offset = cmd_q[0].offset;
        cmd_len = cmd_q[0].len;
      end else cmd_valid = 0;
    end
  end

  initial begin : beat_drv
    bit fire;
    forever begin
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (fire) void'(beat_q.pop_front());
      if (beat_q.size() > 0 && ((s_valid && !fire) || !rand_valid || $urandom_range(3) != 0)) begin
        s_valid = 1;
        s_data = beat_q[0].data;
        s_strb = beat_q[0].strb;
        s_user = beat_q[0].user;
        s_last = beat_q[0].last;
      end else s_valid = 0;
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      m_ready = !rst && !hold_off && (!rand_ready || $urandom_range(3) != 0);
    end
  end

  initial begin : monitor
    exp_t e;
    bit stalled = 0;
    logic [63:0] h_data;
    logic [7:0] h_strb;
    logic h_last;
    forever begin
      @(negedge clk);
      if (rst) stalled = 0;
      else begin
        if (stalled) begin
          check("stall_valid", 64'(m_valid), 64'd1);
          check("stall_data", m_data, h_data);
          check("stall_strb_last", {55'd0, m_strb, m_last}, {55'd0, h_strb, h_last});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %h, expected no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data & e.mask, e.data);
            check("beat_strb_user_last", {49'd0, m_strb, m_user, m_last}, {49'd0, e.strb, e.user, e.last});
          end
        end
        stalled = m_valid && !m_ready;
        h_data = m_data;
        h_strb = m_strb;
        h_last = m_last;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_strb_user_last", {49'd0, m_strb, m_user, m_last}, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    gen_burst(1'b0, 3, 1, -1);
    wait_drain("aligned");
    gen_burst(1'b1, 0, 2, -1);
    wait_drain("single");
    gen_burst(1'b1, 2, 0, -1);
    wait_drain("odd");
    gen_burst(1'b0, 1, 0, -1);
    gen_burst(1'b1, 0, 0, -1);
    wait_drain("back2back");
    gen_burst(1'b0, 7, 0, -1);
    repeat (4) @(posedge clk);
    #2 hold_off = 1;
    repeat (5) @(posedge clk);
    #2 hold_off = 0;
    wait_drain("backpressure");
    rand_valid = 1;
    rand_ready = 1;
    for (int k = 0; k < 40; k++) gen_burst(1'($urandom), $urandom_range(15), 0, -1);
    wait_drain("random");
    check("idle_m_valid", 64'(m_valid), 64'd0);
    check("no_err_clean", 64'(err), 64'd0);
`ifdef AXI_W_PACK_LAST_CHECK_EN
    rand_valid = 0;
    rand_ready = 0;
    gen_burst(1'b0, 1, 0, 0);
    wait_drain("last_check");
    check("err_sticky", 64'(err), 64'd1);
    gen_burst(1'b1, 2, 0, -1);
    wait_drain("after_err");
    check("err_stays", 64'(err), 64'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
